// File: rtl/cpich_tx_gen.sv
// CPICH transmit chip generator: Gold-code scrambled, SF256 all-ones pilot, frame-aligned I/Q chip stream.
// Optional antenna-2 STTD pilot pattern is enabled by defining CPICH_TX_DIV_EN.
module cpich_tx_gen #(
    parameter int AW     = 18,
    parameter int CODE_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CODE_W-1:0] code_n,
    input  logic [AW-2:0]     gain,
`ifdef CPICH_TX_DIV_EN
    input  logic              ant2_sel,
`endif
    output logic              chip_valid,
    input  logic              chip_ready,
    output logic [AW-1:0]     chip_i,
    output logic [AW-1:0]     chip_q,
    output logic              frame_start,
    output logic              slot_start,
    output logic [7:0]        chip_cnt,
    output logic [3:0]        sym_cnt,
    output logic [3:0]        slot_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ADVANCE, LOAD, RUN} state_t;

    state_t            state;
    logic [17:0]       x, y, x_seed;
    logic [CODE_W-1:0] n_q, adv_cnt;
    logic [AW-2:0]     a_q;
    logic              stop_pend;
    logic [7:0]        chip_idx;
    logic [3:0]        sym_idx, slot_idx;

    logic              s_i, s_q, flip, idx_last, out_last;
    logic [AW-1:0]     amp_pos, amp_neg;

    function automatic logic [17:0] x_step(input logic [17:0] v);
        return {v[7] ^ v[0], v[17:1]};
    endfunction

    function automatic logic [17:0] y_step(input logic [17:0] v);
        return {v[10] ^ v[7] ^ v[5] ^ v[0], v[17:1]};
    endfunction

`ifdef CPICH_TX_DIV_EN
    logic       ant2_q;
    logic [7:0] sym_in_frame;
    assign sym_in_frame = 8'(slot_idx) * 8'd10 + 8'(sym_idx);
    assign flip = ant2_q & (sym_in_frame[1] ^ sym_in_frame[0]);
`else
    assign flip = 1'b0;
`endif

    // x/y/idx always describe the next chip to be placed in the output register.
    always_comb begin
        s_i = x[0] ^ y[0];
        s_q = x[15] ^ x[6] ^ x[4] ^ y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10]
            ^ y[11] ^ y[12] ^ y[13] ^ y[14] ^ y[15];
        amp_pos  = {1'b0, a_q};
        amp_neg  = -amp_pos;
        idx_last = (chip_idx == 8'd255) && (sym_idx == 4'd9) && (slot_idx == 4'd14);
        out_last = (chip_cnt == 8'd255) && (sym_cnt == 4'd9) && (slot_cnt == 4'd14);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x           <= 18'h00001;
            y           <= 18'h3FFFF;
            x_seed      <= 18'h00001;
            n_q         <= '0;
            adv_cnt     <= '0;
            a_q         <= '0;
            stop_pend   <= 1'b0;
            chip_idx    <= '0;
            sym_idx     <= '0;
            slot_idx    <= '0;
            chip_valid  <= 1'b0;
            chip_i      <= '0;
            chip_q      <= '0;
            frame_start <= 1'b0;
            slot_start  <= 1'b0;
            chip_cnt    <= '0;
            sym_cnt     <= '0;
            slot_cnt    <= '0;
            busy        <= 1'b0;
`ifdef CPICH_TX_DIV_EN
            ant2_q      <= 1'b0;
`endif
        end else begin
            if (state != IDLE && stop) stop_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q       <= code_n;
                        a_q       <= gain;
                        x         <= 18'h00001;
                        adv_cnt   <= '0;
                        stop_pend <= 1'b0;
                        busy      <= 1'b1;
`ifdef CPICH_TX_DIV_EN
                        ant2_q    <= ant2_sel;
`endif
                        state     <= (code_n == '0) ? LOAD : ADVANCE;
                    end
                end
                ADVANCE: begin
                    x       <= x_step(x);
                    adv_cnt <= adv_cnt + CODE_W'(1);
                    if (adv_cnt == n_q - CODE_W'(1)) state <= LOAD;
                end
                LOAD: begin
                    x_seed   <= x;
                    y        <= 18'h3FFFF;
                    chip_idx <= '0;
                    sym_idx  <= '0;
                    slot_idx <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (chip_valid && chip_ready && out_last && (stop_pend || stop)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        stop_pend   <= 1'b0;
                        chip_valid  <= 1'b0;
                        chip_i      <= '0;
                        chip_q      <= '0;
                        frame_start <= 1'b0;
                        slot_start  <= 1'b0;
                        chip_cnt    <= '0;
                        sym_cnt     <= '0;
                        slot_cnt    <= '0;
                    end else if (!chip_valid || chip_ready) begin
                        chip_valid  <= 1'b1;
                        chip_i      <= (s_i ^ flip) ? amp_neg : amp_pos;
                        chip_q      <= (s_q ^ flip) ? amp_neg : amp_pos;
                        chip_cnt    <= chip_idx;
                        sym_cnt     <= sym_idx;
                        slot_cnt    <= slot_idx;
                        slot_start  <= (chip_idx == 8'd0) && (sym_idx == 4'd0);
                        frame_start <= (chip_idx == 8'd0) && (sym_idx == 4'd0) && (slot_idx == 4'd0);
                        // The code is truncated per frame: the chip after 38399 restarts from the seed.
                        if (idx_last) begin
                            x        <= x_seed;
                            y        <= 18'h3FFFF;
                            chip_idx <= '0;
                            sym_idx  <= '0;
                            slot_idx <= '0;
                        end else begin
                            x        <= x_step(x);
                            y        <= y_step(y);
                            chip_idx <= chip_idx + 8'd1;
                            if (chip_idx == 8'd255) begin
                                if (sym_idx == 4'd9) begin
                                    sym_idx  <= '0;
                                    slot_idx <= slot_idx + 4'd1;
                                end else begin
                                    sym_idx <= sym_idx + 4'd1;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
